sram_march_bist: RTL

//   Built-in self-test initiator for the single-port SRAM (sp_ram). Drives the RAM's
//   we/re/addr/data_in side and checks data_out using the March C- algorithm. Sits

---
 rtl/sram_bist_pkg.sv | 22 ++
 rtl/sram_bist_cmp.sv | 59 +++++
 rtl/sram_march_bist.sv | 95 +++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared types and March C- element constants for the SRAM BIST.
package sram_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;
  typedef enum logic {OP_R, OP_W} op_t;
  function automatic logic elem_down(elem_t e);
    return e == E3 || e == E4;
  endfunction
  function automatic logic elem_rbit(elem_t e);
    return e == E2 || e == E4;
  endfunction
  function automatic logic elem_wbit(elem_t e);
    return e == E1 || e == E3;
  endfunction
  function automatic logic elem_pair(elem_t e);
    return e != E0 && e != E5;
  endfunction
  // Paired elements read first then write; E0 only writes, E5 only reads.
  function automatic op_t elem_op(elem_t e, logic ph);
    return (e == E0 || ph) ? OP_W : OP_R;
  endfunction
endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp: read-latency matched expected/address pipe, comparator and first-fail capture.
module sram_bist_cmp import sram_bist_pkg::*; #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              mismatch_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o
);
  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0] exp_q [RD_LATENCY];
  logic [ADDR_W-1:0] addr_q [RD_LATENCY];
  logic fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  assign mismatch_o = vld_q[RD_LATENCY-1] && rdata_i != exp_q[RD_LATENCY-1];
  assign fail_o = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        exp_q[i] <= '0;
        addr_q[i] <= '0;
      end
      fail_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      vld_q[0] <= push_i;
      exp_q[0] <= exp_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      if (clr_i) begin
        fail_q <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch_o && !fail_q) begin
        fail_q <= 1'b1;
        fail_addr_q <= addr_q[RD_LATENCY-1];
        fail_data_q <= rdata_i;
      end
    end
  end
endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST initiator for a single-port SRAM with pass/fail and first-fail report.
module sram_march_bist import sram_bist_pkg::*; #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [ADDR_W-1:0] AMAX = {ADDR_W{1'b1}};
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);
  state_t state_q, state_d;
  elem_t elem_q, elem_d;
  logic ph_q, ph_d, last_q, last, busy_q, done_q, we_q, re_q, go, down, at_end, mismatch;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q;
  logic [DATA_W-1:0] wdata_q, exp_q;
  logic [1:0] cnt_q;
  op_t op;
  assign busy = busy_q;
  assign done = done_q;
  assign mem_we = we_q;
  assign mem_re = re_q;
  assign mem_addr = maddr_q;
  assign mem_wdata = wdata_q;
  always_comb begin
    op = elem_op(elem_q, ph_q);
    down = elem_down(elem_q);
    at_end = addr_q == (down ? '0 : AMAX);
    ph_d = elem_pair(elem_q) && !ph_q;
    elem_d = (ph_d || !at_end) ? elem_q : elem_t'(elem_q + 3'd1);
    addr_d = ph_d ? addr_q : !at_end ? (down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1))
           : (elem_down(elem_d) ? AMAX : '0);
    last = elem_q == E5 && addr_q == AMAX;
    // A mismatch aborts issue on the very edge it is seen.
    go = state_q == IDLE ? start : state_q == RUN && !mismatch && !last_q;
    state_d = state_q == IDLE ? (start ? RUN : IDLE)
            : state_q == RUN ? (go ? RUN : DRAIN)
            : state_q == DRAIN ? (cnt_q == 2'd0 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q <= E0;
      ph_q <= 1'b0;
      addr_q <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      exp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= state_d == RUN || state_d == DRAIN;
      done_q <= state_d == DONE;
      cnt_q <= state_q == DRAIN ? cnt_q - 2'd1 : CNT_INIT;
      we_q <= go && op == OP_W;
      re_q <= go && op == OP_R;
      maddr_q <= go ? addr_q : '0;
      wdata_q <= (go && op == OP_W) ? {DATA_W{elem_wbit(elem_q)}} : '0;
      exp_q <= {DATA_W{elem_rbit(elem_q)}};
      last_q <= go && last;
      elem_q <= go ? elem_d : E0;
      ph_q <= go && ph_d;
      addr_q <= go ? addr_d : '0;
    end
  end
  sram_bist_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) u_cmp (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == IDLE && start),
    .push_i(re_q),
    .exp_i(exp_q),
    .addr_i(maddr_q),
    .rdata_i(mem_rdata),
    .mismatch_o(mismatch),
    .fail_o(fail),
    .fail_addr_o(fail_addr),
    .fail_data_o(fail_data)
  );
endmodule
